// File: rtl/clock_set_ctrl.sv
// rtl/clock_set_ctrl.sv - time-setting controller for the digital clock
//
// Ports:
//   clk, rst                 clock, synchronous active-low reset
//   key_mode/key_inc/key_dec one-cycle debounced key press pulses
//   tick_1hz                 one-cycle strobe, once per second
//   cur_hour/cur_min/cur_sec live time from the timekeeper
//   set_hour/set_min/set_sec edited time, valid while load_time=1
//   load_time                one-cycle commit strobe to the timekeeper
//   editing                  1 in any edit state
//   field_sel                0=none 1=hour 2=min 3=sec
//   blink                    blink phase for the selected field, 0 in RUN
module clock_set_ctrl #(
  parameter int TIMEOUT_S = 30
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_mode,
  input  logic       key_inc,
  input  logic       key_dec,
  input  logic       tick_1hz,
  input  logic [4:0] cur_hour,
  input  logic [5:0] cur_min,
  input  logic [5:0] cur_sec,
  output logic [4:0] set_hour,
  output logic [5:0] set_min,
  output logic [5:0] set_sec,
  output logic       load_time,
  output logic       editing,
  output logic [1:0] field_sel,
  output logic       blink
);

  localparam int IW = $clog2(TIMEOUT_S + 1);
  localparam logic [IW-1:0] IDLE_LAST = IW'(TIMEOUT_S - 1);

  // Encoding doubles as the field_sel value.
  typedef enum logic [1:0] {
    RUN   = 2'd0,
    SET_H = 2'd1,
    SET_M = 2'd2,
    SET_S = 2'd3
  } state_t;

  state_t        state, state_d;
  logic [4:0]    hour_d;
  logic [5:0]    min_d, sec_d;
  logic          blink_d, load_d;
  logic [IW-1:0] idle, idle_d;
  logic          any_key, inc_only, dec_only;

  // Out-of-range values (captured from a misbehaving timekeeper) wrap to 0 on inc.
  function automatic logic [5:0] step_inc(input logic [5:0] v, input logic [5:0] max);
    return (v >= max) ? 6'd0 : v + 6'd1;
  endfunction

  // Out-of-range values saturate to max on dec, so the field re-enters range.
  function automatic logic [5:0] step_dec(input logic [5:0] v, input logic [5:0] max);
    return (v == 6'd0 || v > max) ? max : v - 6'd1;
  endfunction

  assign any_key  = key_mode | key_inc | key_dec;
  assign inc_only = key_inc & ~key_dec;
  assign dec_only = key_dec & ~key_inc;

  always_comb begin
    state_d = state;
    hour_d  = set_hour;
    min_d   = set_min;
    sec_d   = set_sec;
    blink_d = blink;
    idle_d  = idle;
    load_d  = 1'b0;

    // key_mode takes priority; inc/dec only act when mode is not pressed.
    unique case (state)
      RUN: begin
        if (key_mode) begin
          state_d = SET_H;
          hour_d  = cur_hour;
          min_d   = cur_min;
          sec_d   = cur_sec;
        end
      end
      SET_H: begin
        if (key_mode)      state_d = SET_M;
        else if (inc_only) hour_d = 5'(step_inc({1'b0, set_hour}, 6'd23));
        else if (dec_only) hour_d = 5'(step_dec({1'b0, set_hour}, 6'd23));
      end
      SET_M: begin
        if (key_mode)      state_d = SET_S;
        else if (inc_only) min_d = step_inc(set_min, 6'd59);
        else if (dec_only) min_d = step_dec(set_min, 6'd59);
      end
      SET_S: begin
        if (key_mode) begin
          state_d = RUN;
          load_d  = 1'b1;
        end
        else if (inc_only) sec_d = step_inc(set_sec, 6'd59);
        else if (dec_only) sec_d = step_dec(set_sec, 6'd59);
      end
      default: state_d = RUN;
    endcase

    // Any key press (even a cancelling inc+dec pair) restarts the idle window
    // and beats an expiring tick in the same cycle.
    if (any_key) begin
      idle_d = '0;
    end
    else if (tick_1hz && state != RUN) begin
      if (idle == IDLE_LAST) begin
        state_d = RUN;
        idle_d  = '0;
      end
      else begin
        idle_d = idle + IW'(1);
      end
    end

    if (state_d == RUN)               blink_d = 1'b0;
    else if (state == RUN)            blink_d = 1'b1;
    else if (tick_1hz)                blink_d = ~blink;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= RUN;
      set_hour  <= '0;
      set_min   <= '0;
      set_sec   <= '0;
      load_time <= 1'b0;
      blink     <= 1'b0;
      idle      <= '0;
    end
    else begin
      state     <= state_d;
      set_hour  <= hour_d;
      set_min   <= min_d;
      set_sec   <= sec_d;
      load_time <= load_d;
      blink     <= blink_d;
      idle      <= idle_d;
    end
  end

  assign editing   = (state != RUN);
  assign field_sel = state;

endmodule
